// File: rtl/pi_output_limiter_pkg.sv
// Shared types and constants for the PI output limiter.
// Double-precision constants double as limit defaults and test values.
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif
`ifndef N_WindTurbine
`define N_WindTurbine 8
`endif

package pi_output_limiter_pkg;

  localparam int WIDTH_DEF = `EXTENDED_SINGLE;
  localparam int N_CH_DEF  = `N_WindTurbine;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [63:0] FP_POS_ZERO = 64'h0000000000000000;
  localparam logic [63:0] FP_NEG_ZERO = 64'h8000000000000000;
  localparam logic [63:0] FP_HALF     = 64'h3FE0000000000000;
  localparam logic [63:0] FP_POS_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] FP_NEG_ONE  = 64'hBFF0000000000000;
  localparam logic [63:0] FP_TWO      = 64'h4000000000000000;
  localparam logic [63:0] FP_POS_INF  = 64'h7FF0000000000000;
  localparam logic [63:0] FP_NEG_INF  = 64'hFFF0000000000000;
  localparam logic [63:0] FP_QNAN     = 64'h7FF8000000000001;

  // Maps sign-magnitude doubles onto an unsigned total order.
  function automatic logic [63:0] order_key(input logic [63:0] v);
    return v[63] ? ~v : {1'b1, v[62:0]};
  endfunction

endpackage

// File: rtl/fp64_order_key.sv
// Sign-magnitude to unsigned-ordered key mapping for doubles.
// Unsigned compare of two keys gives the IEEE total order.
module fp64_order_key
  import pi_output_limiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] key
);

  assign key = x[WIDTH-1] ? ~x : {1'b1, x[WIDTH-2:0]};

endmodule

// File: rtl/pi_output_limiter.sv
// Two-stage clamp of a time-multiplexed double-precision burst.
// Flags per-channel saturation, NaN input and mid-burst restarts.
module pi_output_limiter
  import pi_output_limiter_pkg::*;
#(
  parameter int                N_CH     = N_CH_DEF,
  parameter int                WIDTH    = WIDTH_DEF,
  parameter logic [WIDTH-1:0]  LIMIT_HI = FP_POS_ONE,
  parameter logic [WIDTH-1:0]  LIMIT_LO = FP_POS_ZERO
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sta,
  input  logic [WIDTH-1:0]         x,
  output logic [WIDTH-1:0]         y,
  output logic                     y_valid,
  output logic [$clog2(N_CH)-1:0]  y_ch,
  output logic                     done_sig,
  output logic [N_CH-1:0]          sat_hi,
  output logic [N_CH-1:0]          sat_lo,
  output logic                     nan_err,
  output logic                     overrun
);

  localparam int CW = $clog2(N_CH);
  localparam logic [WIDTH-1:0] KEY_HI = order_key(LIMIT_HI);
  localparam logic [WIDTH-1:0] KEY_LO = order_key(LIMIT_LO);
  localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    ch_cnt, ch_cnt_nx;
  logic             cap;
  logic [CW-1:0]    cap_ch;
  logic [WIDTH-1:0] key_x;

  logic             s1_vld, s1_gt, s1_lt, s1_nan, s1_last;
  logic [WIDTH-1:0] s1_x;
  logic [CW-1:0]    s1_ch;

  logic [WIDTH-1:0] y_nx;
  logic             hi_nx, lo_nx, nan_nx;

  fp64_order_key #(.WIDTH(WIDTH)) u_key (
    .x   (x),
    .key (key_x)
  );

  always_comb begin
    state_nx  = state;
    ch_cnt_nx = ch_cnt;
    cap       = 1'b0;
    cap_ch    = ch_cnt;
    unique case (state)
      IDLE: begin
        if (sta) begin
          cap       = 1'b1;
          cap_ch    = '0;
          ch_cnt_nx = CW'(1);
          state_nx  = RUN;
        end
      end
      RUN: begin
        cap = 1'b1;
        // A new start abandons the running burst.
        if (sta) begin
          cap_ch    = '0;
          ch_cnt_nx = CW'(1);
        end else if (ch_cnt == LAST_CH) begin
          ch_cnt_nx = '0;
          state_nx  = IDLE;
        end else begin
          ch_cnt_nx = ch_cnt + CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch_cnt  <= '0;
      s1_vld  <= 1'b0;
      s1_x    <= '0;
      s1_gt   <= 1'b0;
      s1_lt   <= 1'b0;
      s1_nan  <= 1'b0;
      s1_ch   <= '0;
      s1_last <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state  <= state_nx;
      ch_cnt <= ch_cnt_nx;
      s1_vld <= cap;
      if (cap) begin
        s1_x    <= x;
        s1_gt   <= key_x > KEY_HI;
        s1_lt   <= key_x < KEY_LO;
        s1_nan  <= (x[62:52] == 11'h7FF) && (x[51:0] != '0);
        s1_ch   <= cap_ch;
        s1_last <= cap_ch == LAST_CH;
      end
      if (sta && state == RUN) begin
        overrun <= 1'b1;
      end
    end
  end

  // NaN wins over the ordering flags, which are meaningless for it.
  always_comb begin
    y_nx   = s1_x;
    hi_nx  = 1'b0;
    lo_nx  = 1'b0;
    nan_nx = 1'b0;
    if (s1_nan) begin
      y_nx   = LIMIT_LO;
      nan_nx = 1'b1;
    end else if (s1_gt) begin
      y_nx  = LIMIT_HI;
      hi_nx = 1'b1;
    end else if (s1_lt) begin
      y_nx  = LIMIT_LO;
      lo_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= '0;
      y_valid  <= 1'b0;
      y_ch     <= '0;
      done_sig <= 1'b0;
      sat_hi   <= '0;
      sat_lo   <= '0;
      nan_err  <= 1'b0;
    end else begin
      y_valid  <= s1_vld;
      done_sig <= s1_vld & s1_last;
      if (s1_vld) begin
        y             <= y_nx;
        y_ch          <= s1_ch;
        sat_hi[s1_ch] <= hi_nx;
        sat_lo[s1_ch] <= lo_nx;
        if (nan_nx) begin
          nan_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_output_limiter.sv
// Scoreboard bench for pi_output_limiter with a real-valued reference.
// Directed corner bursts followed by randomized traffic and resets.
module tb_pi_output_limiter;
  import pi_output_limiter_pkg::*;

  localparam int N = 4;
  localparam logic [63:0] HI = FP_POS_ONE;
  localparam logic [63:0] LO = FP_POS_ZERO;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sta = 1'b0;
  logic [63:0]   x = '0;
  logic [63:0]   y;
  logic          y_valid;
  logic [1:0]    y_ch;
  logic          done_sig;
  logic [N-1:0]  sat_hi, sat_lo;
  logic          nan_err, overrun;

  pi_output_limiter #(
    .N_CH(N), .WIDTH(64), .LIMIT_HI(HI), .LIMIT_LO(LO)
  ) dut (
    .clk(clk), .rst(rst), .sta(sta), .x(x),
    .y(y), .y_valid(y_valid), .y_ch(y_ch), .done_sig(done_sig),
    .sat_hi(sat_hi), .sat_lo(sat_lo),
    .nan_err(nan_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  y;
    int           ch;
    bit           done;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    bit           nan;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           n_done = 0;
  int           exp_done = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  bit           m_nan = 0;
  bit           m_ovr = 0;
  int           pos = N;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void classify(input logic [63:0] v,
                                   output logic [63:0] r,
                                   output bit h, output bit l,
                                   output bit n);
    real rv, rh, rl;
    n = (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
    h = 0;
    l = 0;
    r = v;
    if (n) begin
      r = LO;
    end else begin
      rv = $bitstoreal(v);
      rh = $bitstoreal(HI);
      rl = $bitstoreal(LO);
      if (rv > rh) begin
        h = 1;
        r = HI;
      end else if (rv < rl || (rv == rl && v[63] && !LO[63])) begin
        l = 1;
        r = LO;
      end
    end
  endfunction

  task automatic capture(bit s, logic [63:0] v);
    exp_t e;
    bit h, l, n;
    if (s) begin
      if (pos < N) m_ovr = 1;
      pos = 0;
    end
    if (pos < N) begin
      classify(v, e.y, h, l, n);
      e.ch = pos;
      e.done = (pos == N - 1);
      m_hi[pos] = h;
      m_lo[pos] = l;
      if (n) m_nan = 1;
      e.hi = m_hi;
      e.lo = m_lo;
      e.nan = m_nan;
      e.cyc = cyc + 2;
      q.push_back(e);
      if (e.done) exp_done++;
      pos++;
    end
  endtask

  task automatic step(bit s, logic [63:0] v);
    @(posedge clk);
    #1;
    sta = s;
    x = v;
    capture(s, v);
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1;
    rst = 1;
    sta = 0;
    x = '0;
    @(negedge clk);
    #1;
    foreach (q[i]) if (q[i].done) exp_done--;
    q.delete();
    m_hi = '0;
    m_lo = '0;
    m_nan = 0;
    m_ovr = 0;
    pos = N;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_y", y, 64'd0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_y_ch", y_ch, 0);
    chk("rst_done", done_sig, 0);
    chk("rst_sat_hi", sat_hi, 0);
    chk("rst_sat_lo", sat_lo, 0);
    chk("rst_nan_err", nan_err, 0);
    chk("rst_overrun", overrun, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (y_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_y: got y=%h ch=%0d expected no output", y, y_ch);
      end else begin
        e = q.pop_front();
        chk("y", y, e.y);
        chk("y_ch", y_ch, e.ch);
        chk("done_sig", done_sig, e.done);
        chk("sat_hi", sat_hi, e.hi);
        chk("sat_lo", sat_lo, e.lo);
        chk("nan_err", nan_err, e.nan);
        chk("latency_cyc", cyc, e.cyc);
      end
    end else begin
      chk("idle_done", done_sig, 0);
    end
    if (done_sig) n_done++;
  end

  function automatic logic [63:0] rand_val();
    logic [63:0] pool [10];
    pool = '{FP_POS_ZERO, FP_NEG_ZERO, FP_HALF, FP_POS_ONE, FP_NEG_ONE,
             FP_TWO, FP_POS_INF, FP_NEG_INF, FP_QNAN, 64'hFFF8000000000000};
    case ($urandom_range(0, 3))
      0: return pool[$urandom_range(0, 9)];
      1: return {$urandom(), $urandom()};
      2: return $urandom_range(0, 1) ? 64'h3FEFFFFFFFFFFFFF
                                     : 64'h3FF0000000000001;
      default:
        return $realtobits((real'(int'($urandom_range(0, 2000))) - 500.0) / 1000.0);
    endcase
  endfunction

  initial begin
    do_rst();

    step(1, FP_HALF);
    step(0, FP_TWO);
    step(0, FP_NEG_ONE);
    step(0, FP_POS_ONE);
    repeat (3) step(0, '0);
    @(negedge clk);
    chk("burst1_sat_hi", sat_hi, 4'b0010);
    chk("burst1_sat_lo", sat_lo, 4'b0100);

    step(1, FP_NEG_ZERO);
    step(0, FP_POS_ZERO);
    step(0, FP_QNAN);
    step(0, FP_POS_INF);
    repeat (3) step(0, '0);
    @(negedge clk);
    chk("burst2_sat_hi", sat_hi, 4'b1000);
    chk("burst2_sat_lo", sat_lo, 4'b0001);
    chk("burst2_nan_err", nan_err, 1);
    chk("pre_overrun", overrun, 0);

    step(1, FP_POS_ONE);
    step(0, FP_TWO);
    step(1, FP_HALF);
    step(0, FP_NEG_INF);
    @(negedge clk);
    chk("overrun_set", overrun, 1);
    step(0, FP_HALF);
    step(0, FP_POS_ZERO);
    repeat (3) step(0, '0);

    step(1, FP_POS_ONE);
    do_rst();
    step(1, FP_TWO);
    step(0, FP_HALF);
    step(0, FP_NEG_ZERO);
    step(0, FP_POS_ZERO);

    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < N; c++) begin
        step(c == 0, rand_val());
      end
    end
    repeat (3) step(0, '0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_rst();
      end else begin
        step($urandom_range(0, 5) == 0, rand_val());
      end
    end

    repeat (8) step(0, '0);
    @(negedge clk);
    chk("drain_queue", q.size(), 0);
    chk("done_count", n_done, exp_done);
    chk("overrun_final", overrun, m_ovr);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
